// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: four requesters share one 16x16 Wallace-tree multiplier
// through a two-stage pipeline (S0 operands, S1 product), with round-robin
// grant and a consumed-result counter.

// Unsigned 16x16 multiplier: partial products reduced by layers of 3:2
// carry-save compressors (16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2 rows), then one
// final carry-propagate add.
module WT_Multiplier16x16 (
  output logic [31:0] product,
  input  logic [15:0] A,
  input  logic [15:0] B
);

  // Number of rows left after s compression layers, starting from 16.
  function automatic int rows_at(input int s);
    int n;
    n = 16;
    for (int k = 0; k < s; k++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  logic [31:0] lvl [7][16];

  genvar gi, gs, gg, gr, gz;
  generate
    // Partial products: row i is A shifted by i, gated by B[i].
    for (gi = 0; gi < 16; gi++) begin : g_pp
      assign lvl[0][gi] = B[gi] ? ({16'd0, A} << gi) : 32'd0;
    end

    // Each layer compresses groups of three rows into a sum row and a
    // shifted carry row; leftover rows pass straight through.
    for (gs = 0; gs < 6; gs++) begin : g_stage
      localparam int NI = rows_at(gs);
      localparam int NG = NI / 3;
      localparam int NR = NI % 3;
      localparam int NO = 2 * NG + NR;
      for (gg = 0; gg < NG; gg++) begin : g_csa
        assign lvl[gs+1][2*gg] = lvl[gs][3*gg] ^ lvl[gs][3*gg+1] ^ lvl[gs][3*gg+2];
        assign lvl[gs+1][2*gg+1] = ((lvl[gs][3*gg] & lvl[gs][3*gg+1]) |
                                    (lvl[gs][3*gg] & lvl[gs][3*gg+2]) |
                                    (lvl[gs][3*gg+1] & lvl[gs][3*gg+2])) << 1;
      end
      for (gr = 0; gr < NR; gr++) begin : g_pass
        assign lvl[gs+1][2*NG+gr] = lvl[gs][3*NG+gr];
      end
      for (gz = NO; gz < 16; gz++) begin : g_zero
        assign lvl[gs+1][gz] = 32'd0;
      end
    end
  endgenerate

  assign product = lvl[6][0] + lvl[6][1];

endmodule

module mul_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     out_p,
  output logic [1:0]         out_id,
  output logic [15:0]        done_cnt
);

  logic         s0_valid;
  logic [W-1:0] s0_a;
  logic [W-1:0] s0_b;
  logic [1:0]   s0_id;
  logic [1:0]   rr_ptr;
  logic [1:0]   grant_id;
  logic [1:0]   idx;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic [2*W-1:0] mul_p;
  logic         adv1;
  logic         s0_accept;
  logic         transfer;

  assign adv1      = !out_valid || out_ready;
  assign s0_accept = !s0_valid || adv1;
  assign transfer  = |req_ready;

  // The shared multiplier only ever sees the registered S0 operands.
  WT_Multiplier16x16 u_mul (
    .product (mul_p),
    .A       (s0_a),
    .B       (s0_b)
  );

  // Round-robin grant from rr_ptr upward, plus the matching operand mux.
  always_comb begin
    req_ready = '0;
    grant_id  = 2'd0;
    idx       = rr_ptr;
    sel_a     = '0;
    sel_b     = '0;
    if (rst_n && s0_accept) begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        idx = rr_ptr + 2'(k);
        if (req_valid[idx]) begin
          req_ready      = '0;
          req_ready[idx] = 1'b1;
          grant_id       = idx;
        end
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == 2'(i)) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  // Pipeline stages, round-robin pointer and consumed-result counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_valid  <= 1'b0;
      s0_a      <= '0;
      s0_b      <= '0;
      s0_id     <= 2'd0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_id    <= 2'd0;
      rr_ptr    <= 2'd0;
      done_cnt  <= 16'd0;
    end else begin
      if (adv1) begin
        out_valid <= s0_valid;
        if (s0_valid) begin
          out_p  <= mul_p;
          out_id <= s0_id;
        end
      end
      if (transfer) begin
        s0_valid <= 1'b1;
        s0_a     <= sel_a;
        s0_b     <= sel_b;
        s0_id    <= grant_id;
        rr_ptr   <= grant_id + 2'd1;
      end else if (adv1) begin
        s0_valid <= 1'b0;
      end
      if (out_valid && out_ready) begin
        done_cnt <= done_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: directed scenarios plus random
// traffic, compared against a transaction-level model (grant order from a
// round-robin pointer, a FIFO of expected products, and an in-flight count).
module tb_mul_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p;
  logic [1:0]  out_id;
  logic [15:0] done_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Requester-side state held by the bench.
  logic [3:0]  pend;
  logic [15:0] pa [4];
  logic [15:0] pb [4];

  // Transaction-level model state.
  int          m_rr;
  logic [31:0] q_p [$];
  logic [1:0]  q_id [$];
  bit          m_new;
  logic [15:0] m_done;

  logic [3:0]  er;
  logic        ev;
  logic [31:0] ep;
  logic [1:0]  eid;

  mul_share_arbiter #(.N_REQ(4), .W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_id    (out_id),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive();
    req_valid = pend;
    for (int i = 0; i < 4; i++) begin
      req_a[16*i +: 16] = pa[i];
      req_b[16*i +: 16] = pb[i];
    end
  endtask

  task automatic arm(input int i, input logic [15:0] a, input logic [15:0] b);
    pend[i] = 1'b1;
    pa[i]   = a;
    pb[i]   = b;
  endtask

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return 16'hFFFF;
      1:       return 16'd0;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    m_rr   = 0;
    m_new  = 0;
    m_done = 16'd0;
    q_p.delete();
    q_id.delete();
  endtask

  // Expected outputs: the pipe holds two items, so a grant is possible unless
  // two are in flight and the consumer stalls; a lone item granted at the last
  // edge still sits in S0 and is not yet visible.
  task automatic model_expect(output logic [3:0] x_ready, output logic x_valid,
                              output logic [31:0] x_p, output logic [1:0] x_id);
    int sz;
    sz      = q_p.size();
    x_ready = '0;
    x_p     = '0;
    x_id    = '0;
    if (!(sz == 2 && !out_ready)) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_rr + k) % 4;
        if (pend[j] && x_ready == 4'd0) x_ready[j] = 1'b1;
      end
    end
    x_valid = (sz > 0) && !(sz == 1 && m_new);
    if (x_valid) begin
      x_p  = q_p[0];
      x_id = q_id[0];
    end
  endtask

  task automatic model_advance(input logic [3:0] g, input logic v);
    if (v && out_ready) begin
      void'(q_p.pop_front());
      void'(q_id.pop_front());
      m_done = m_done + 16'd1;
    end
    m_new = 0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) begin
        q_p.push_back({16'd0, pa[i]} * {16'd0, pb[i]});
        q_id.push_back(2'(i));
        m_rr    = (i + 1) % 4;
        pend[i] = 1'b0;
        m_new   = 1;
      end
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    pend  = '0;
    out_ready = 1'b1;
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) arm(i, 16'd7, 16'd9);
    drive();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_ready got %b want 0000", req_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %b want 0", out_valid); end
    n_checks++;
    if (out_p !== 32'd0 || out_id !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_data got %0d/%0d want 0/0", out_p, out_id); end
    n_checks++;
    if (done_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_cnt got %0d want 0", done_cnt); end
    @(posedge clk);
    #1;
    pend  = '0;
    drive();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    logic [31:0] got_p;
    logic [1:0]  got_id;
    int          seen;
    reset_dut();
    seen = 0;
    got_p = '0;
    got_id = '0;
    arm(0, 16'd1024, 16'd60);
    drive();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      model_expect(er, ev, ep, eid);
      n_checks++;
      if (req_ready !== er) begin n_fail++; $display("[TB] FAIL single_ready got %b want %b", req_ready, er); end
      n_checks++;
      if (out_valid !== ev) begin n_fail++; $display("[TB] FAIL single_valid got %b want %b", out_valid, ev); end
      if (out_valid && out_ready) begin seen++; got_p = out_p; got_id = out_id; end
      model_advance(er, ev);
      @(posedge clk);
      #1;
      drive();
    end
    @(negedge clk);
    n_checks++;
    if (seen != 1 || got_p !== 32'd61440 || got_id !== 2'd0)
      begin n_fail++; $display("[TB] FAIL single_result got n=%0d p=%0d id=%0d want n=1 p=61440 id=0", seen, got_p, got_id); end
    n_checks++;
    if (done_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL single_cnt got %0d want 1", done_cnt); end
  endtask

  task automatic test_all_four();
    logic [3:0]  grants [$];
    logic [31:0] prods [$];
    logic [1:0]  ids [$];
    logic [31:0] want_p [4];
    reset_dut();
    want_p[0] = 32'd3932100;
    want_p[1] = 32'd500000;
    want_p[2] = 32'd6;
    want_p[3] = 32'd4294836225;
    arm(0, 16'd65535, 16'd60);
    arm(1, 16'd1000, 16'd500);
    arm(2, 16'd2, 16'd3);
    arm(3, 16'd65535, 16'd65535);
    drive();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      model_expect(er, ev, ep, eid);
      n_checks++;
      if (req_ready !== er) begin n_fail++; $display("[TB] FAIL four_ready got %b want %b", req_ready, er); end
      n_checks++;
      if (out_valid !== ev) begin n_fail++; $display("[TB] FAIL four_valid got %b want %b", out_valid, ev); end
      if (ev) begin
        n_checks++;
        if (out_p !== ep || out_id !== eid) begin n_fail++; $display("[TB] FAIL four_data got %0d/%0d want %0d/%0d", out_p, out_id, ep, eid); end
      end
      if (req_ready != 4'd0) grants.push_back(req_ready);
      if (out_valid && out_ready) begin prods.push_back(out_p); ids.push_back(out_id); end
      model_advance(er, ev);
      @(posedge clk);
      #1;
      drive();
    end
    n_checks++;
    if (grants.size() != 4 || prods.size() != 4)
      begin n_fail++; $display("[TB] FAIL four_count got grants=%0d results=%0d want 4/4", grants.size(), prods.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (grants[i] !== 4'(1 << i) || prods[i] !== want_p[i] || ids[i] !== 2'(i))
          begin n_fail++; $display("[TB] FAIL four_order[%0d] got g=%b p=%0d id=%0d want g=%b p=%0d id=%0d", i, grants[i], prods[i], ids[i], 4'(1 << i), want_p[i], i); end
      end
    end
  endtask

  task automatic test_backpressure();
    int stall_grants;
    reset_dut();
    stall_grants = 0;
    out_ready = 1'b0;
    arm(1, 16'd300, 16'd7);
    arm(2, 16'd40000, 16'd3);
    drive();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      model_expect(er, ev, ep, eid);
      n_checks++;
      if (req_ready !== er) begin n_fail++; $display("[TB] FAIL bp_ready got %b want %b", req_ready, er); end
      n_checks++;
      if (out_valid !== ev) begin n_fail++; $display("[TB] FAIL bp_valid got %b want %b", out_valid, ev); end
      if (ev) begin
        n_checks++;
        if (out_p !== ep || out_id !== eid) begin n_fail++; $display("[TB] FAIL bp_data got %0d/%0d want %0d/%0d", out_p, out_id, ep, eid); end
      end
      if (c < 5 && req_ready != 4'd0) stall_grants++;
      model_advance(er, ev);
      @(posedge clk);
      #1;
      if (!pend[1]) arm(1, rnd_op(), rnd_op());
      if (c >= 4) out_ready = 1'b1;
      drive();
    end
    n_checks++;
    if (stall_grants != 2) begin n_fail++; $display("[TB] FAIL bp_stall_grants got %0d want 2", stall_grants); end
    pend = '0;
    drive();
  endtask

  task automatic test_fairness();
    logic [3:0] grants [$];
    reset_dut();
    arm(0, rnd_op(), rnd_op());
    arm(3, rnd_op(), rnd_op());
    drive();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      model_expect(er, ev, ep, eid);
      n_checks++;
      if (req_ready !== er) begin n_fail++; $display("[TB] FAIL fair_ready got %b want %b", req_ready, er); end
      if (ev) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_p !== ep || out_id !== eid) begin n_fail++; $display("[TB] FAIL fair_data got %b %0d/%0d want 1 %0d/%0d", out_valid, out_p, out_id, ep, eid); end
      end
      grants.push_back(req_ready);
      model_advance(er, ev);
      @(posedge clk);
      #1;
      if (!pend[0]) arm(0, rnd_op(), rnd_op());
      if (!pend[3]) arm(3, rnd_op(), rnd_op());
      drive();
    end
    for (int j = 0; j < 10; j++) begin
      n_checks++;
      if (grants[j] !== ((j % 2 == 0) ? 4'b0001 : 4'b1000))
        begin n_fail++; $display("[TB] FAIL fair_grant[%0d] got %b want %b", j, grants[j], (j % 2 == 0) ? 4'b0001 : 4'b1000); end
    end
    pend = '0;
    drive();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      model_expect(er, ev, ep, eid);
      n_checks++;
      if (req_ready !== er) begin n_fail++; $display("[TB] FAIL rand_ready cyc %0d got %b want %b", c, req_ready, er); end
      n_checks++;
      if (out_valid !== ev) begin n_fail++; $display("[TB] FAIL rand_valid cyc %0d got %b want %b", c, out_valid, ev); end
      if (ev) begin
        n_checks++;
        if (out_p !== ep || out_id !== eid) begin n_fail++; $display("[TB] FAIL rand_data cyc %0d got %0d/%0d want %0d/%0d", c, out_p, out_id, ep, eid); end
      end
      n_checks++;
      if (done_cnt !== m_done) begin n_fail++; $display("[TB] FAIL rand_cnt cyc %0d got %0d want %0d", c, done_cnt, m_done); end
      model_advance(er, ev);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) arm(i, rnd_op(), rnd_op());
      out_ready = ($urandom_range(0, 3) != 0);
      drive();
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) if (!pend[i]) arm(i, rnd_op(), rnd_op());
    drive();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      model_expect(er, ev, ep, eid);
      n_checks++;
      if (req_ready !== er) begin n_fail++; $display("[TB] FAIL mid_ready got %b want %b", req_ready, er); end
      model_advance(er, ev);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (!pend[i]) arm(i, rnd_op(), rnd_op());
      drive();
    end
    rst_n     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL mid_rst_ready got %b want 0000", req_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    pend = 4'b1010;
    drive();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || done_cnt !== 16'd0)
      begin n_fail++; $display("[TB] FAIL mid_after got valid=%b cnt=%0d want 0/0", out_valid, done_cnt); end
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("[TB] FAIL mid_first_grant got %b want 0010", req_ready); end
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      model_expect(er, ev, ep, eid);
      n_checks++;
      if (out_valid !== ev || (ev && (out_p !== ep || out_id !== eid)))
        begin n_fail++; $display("[TB] FAIL mid_drain got %b %0d/%0d want %b %0d/%0d", out_valid, out_p, out_id, ev, ep, eid); end
      model_advance(er, ev);
      @(posedge clk);
      #1;
      drive();
    end
  endtask

  task automatic test_counter_wrap();
    int  cons;
    bit  hit_top;
    bit  finished;
    reset_dut();
    cons     = 0;
    hit_top  = 0;
    finished = 0;
    arm(0, 16'd3, 16'd5);
    drive();
    for (int c = 0; c < 70000 && !finished; c++) begin
      @(negedge clk);
      if (cons == 65535 && !hit_top) begin
        hit_top = 1;
        n_checks++;
        if (done_cnt !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL wrap_top got %0d want 65535", done_cnt); end
      end
      if (cons == 65536) begin
        finished = 1;
        n_checks++;
        if (done_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL wrap_zero got %0d want 0", done_cnt); end
      end else begin
        if (out_valid && out_ready) cons++;
        @(posedge clk);
        #1;
      end
    end
    if (!finished) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL wrap_timeout got %0d results want 65536", cons);
    end
    pend = '0;
    drive();
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    pend      = '0;
    for (int i = 0; i < 4; i++) begin pa[i] = '0; pb[i] = '0; end
    drive();
    model_reset();
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_fairness();
    test_random();
    test_reset_midstream();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
